// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, default latencies.
// MDU_MADD_EN enables the multiply-accumulate op codes.
package mdu_pkg;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    function automatic logic is_mul_op(input logic [3:0] op);
        logic r;
        r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 64-bit product / {remainder,quotient} from latched operands.
// With MDU_MADD_EN the product is also accumulated into the supplied {hi,lo}.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] hilo,
    output logic [63:0] res,
    output logic        wr
);

    logic signed [63:0] sprod;
    logic [63:0]        uprod;
    logic [31:0]        mag_a, mag_b, div_b, uq, ur, sq, sr;

    assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod = {32'd0, a} * {32'd0, b};

    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly.
    assign mag_a = (op == OP_DIV && a[31]) ? (~a + 32'd1) : a;
    assign mag_b = (op == OP_DIV && b[31]) ? (~b + 32'd1) : b;
    assign div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign uq    = mag_a / div_b;
    assign ur    = mag_a % div_b;
    assign sq    = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
    assign sr    = a[31] ? (~ur + 32'd1) : ur;

`ifndef MDU_MADD_EN
    logic [63:0] unused_hilo;
    assign unused_hilo = hilo;
`endif

    always_comb begin
        res = 64'd0;
        wr  = 1'b0;
        case (op)
            OP_MULT:  begin res = sprod; wr = 1'b1; end
            OP_MULTU: begin res = uprod; wr = 1'b1; end
            OP_DIV:   begin res = {sr, sq}; wr = (b != 32'd0); end
            OP_DIVU:  begin res = {ur, uq}; wr = (b != 32'd0); end
`ifdef MDU_MADD_EN
            OP_MADD:  begin res = hilo + sprod; wr = 1'b1; end
            OP_MADDU: begin res = hilo + uprod; wr = 1'b1; end
            OP_MSUB:  begin res = hilo - sprod; wr = 1'b1; end
            OP_MSUBU: begin res = hilo - uprod; wr = 1'b1; end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: busy-counter FSM, HI/LO ownership and stall request for the E stage.
// MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU (multiply latency).
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use,
    input  logic        cancel,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_e  state, state_next;
    logic [CW-1:0] count;
    logic [3:0]  lat_op;
    logic [31:0] lat_a, lat_b;
    logic [63:0] res;
    logic        res_wr, accept, long_op, done;

    assign accept  = start && !cancel && (state == ST_IDLE);
    assign long_op = is_mul_op(op) || is_div_op(op);
    assign done    = (state == ST_BUSY) && (count == CW'(1));

    mdu_arith u_arith (
        .op   (lat_op),
        .a    (lat_a),
        .b    (lat_b),
        .hilo ({hi, lo}),
        .res  (res),
        .wr   (res_wr)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept && long_op) state_next = ST_BUSY;
            ST_BUSY: if (count == CW'(1))   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            lat_op <= 4'd0;
            lat_a  <= 32'd0;
            lat_b  <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else if (accept) begin
            if (long_op) begin
                lat_op <= op;
                lat_a  <= rs_val;
                lat_b  <= rt_val;
                count  <= is_div_op(op) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
            end else if (op == OP_MTHI) begin
                hi <= rs_val;
            end else if (op == OP_MTLO) begin
                lo <= rs_val;
            end
        end else if (state == ST_BUSY) begin
            count <= count - CW'(1);
            // Divide-by-zero leaves HI/LO untouched but still burns the full latency.
            if (done && res_wr) {hi, lo} <= res;
        end
    end

    assign busy      = (state == ST_BUSY);
    assign stall_req = md_use && (busy || start);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl; MDU_MADD_EN adds the accumulate scenario.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, md_use, cancel;
    logic [3:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, stall_req;
    logic [31:0] hi, lo;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .md_use(md_use), .cancel(cancel),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    // Called at a negedge; presents one op for one cycle and counts busy cycles.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int nb);
        start = 1'b1; op = o; rs_val = a; rt_val = b; md_use = 1'b1; cancel = 1'b0;
        @(negedge clk);
        start = 1'b0; md_use = 1'b0; op = OP_NONE;
        nb = 0;
        while (busy && nb < 50) begin
            nb++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 0; md_use = 0; cancel = 0; op = OP_NONE; rs_val = 0; rt_val = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
    endtask

    task automatic test_mult;
        int nb;
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, nb);
        total++; if (nb != 5) begin bad++; $display("FAIL mult_busy got=%0d exp=5", nb); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        total++; if (lo !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
        run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, nb);
        total++; if (nb != 5) begin bad++; $display("FAIL multu_busy got=%0d exp=5", nb); end
        total++; if (hi !== 32'h2) begin bad++; $display("FAIL multu_hi got=%h exp=2", hi); end
        total++; if (lo !== 32'hFFFF_FFFA) begin bad++; $display("FAIL multu_lo got=%h exp=fffffffa", lo); end
    endtask

    task automatic test_div;
        int nb;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, nb);
        total++; if (nb != 10) begin bad++; $display("FAIL div_busy got=%0d exp=10", nb); end
        total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb);
        total++; if (lo !== 32'h8000_0000) begin bad++; $display("FAIL divovf_lo got=%h exp=80000000", lo); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL divovf_hi got=%h exp=0", hi); end
        run_op(OP_DIVU, 32'd17, 32'd5, nb);
        total++; if (lo !== 32'd3 || hi !== 32'd2) begin bad++; $display("FAIL divu got=%h:%h exp=2:3", hi, lo); end
        run_op(OP_DIVU, 32'd7, 32'd0, nb);
        total++; if (nb != 10) begin bad++; $display("FAIL div0_busy got=%0d exp=10", nb); end
        total++; if (hi !== 32'd2 || lo !== 32'd3) begin bad++; $display("FAIL div0_keep got=%h:%h exp=2:3", hi, lo); end
    endtask

    task automatic test_stall;
        int ns;
        start = 1'b1; op = OP_MULT; rs_val = 32'd6; rt_val = 32'd7; md_use = 1'b1; cancel = 1'b0;
        #1;
        total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL stall_accept got=%0b exp=1", stall_req); end
        @(negedge clk);
        start = 1'b0; op = OP_NONE;  // mflo now waits in E with md_use held
        ns = 1;
        while (stall_req && ns < 50) begin ns++; @(negedge clk); end
        total++; if (ns != 6) begin bad++; $display("FAIL stall_cycles got=%0d exp=6", ns); end
        total++; if (lo !== 32'd42 || hi !== 32'd0) begin bad++; $display("FAIL stall_mflo got=%h:%h exp=0:2a", hi, lo); end
        md_use = 1'b0;
    endtask

    task automatic test_mt_cancel;
        start = 1'b1; op = OP_MTHI; rs_val = 32'h1234; cancel = 1'b1;
        @(negedge clk);
        total++; if (hi !== 32'd0 || busy !== 1'b0) begin bad++; $display("FAIL mthi_cancel got hi=%h busy=%0b exp hi=0 busy=0", hi, busy); end
        cancel = 1'b0;
        @(negedge clk);
        total++; if (hi !== 32'h1234 || busy !== 1'b0) begin bad++; $display("FAIL mthi got hi=%h busy=%0b exp hi=1234 busy=0", hi, busy); end
        op = OP_MTLO; rs_val = 32'h55;
        @(negedge clk);
        total++; if (lo !== 32'h55 || hi !== 32'h1234) begin bad++; $display("FAIL mtlo got=%h:%h exp=1234:55", hi, lo); end
        op = OP_MULT; rs_val = 32'd9; rt_val = 32'd9; cancel = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0 || lo !== 32'h55) begin bad++; $display("FAIL mult_cancel got busy=%0b lo=%h exp busy=0 lo=55", busy, lo); end
        op = 4'd12; cancel = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || lo !== 32'h55) begin bad++; $display("FAIL unknown_op got busy=%0b lo=%h exp busy=0 lo=55", busy, lo); end
        start = 1'b0; op = OP_NONE;
    endtask

    task automatic test_busy_ignore;
        int nb;
        start = 1'b1; op = OP_MULT; rs_val = 32'd2; rt_val = 32'd3; md_use = 1'b1;
        @(negedge clk);
        op = OP_DIV; rs_val = 32'd100; rt_val = 32'd10; cancel = 1'b1;  // held start + cancel while busy
        nb = 0;
        while (busy && nb < 50) begin nb++; @(negedge clk); end
        start = 1'b0; cancel = 1'b0; md_use = 1'b0; op = OP_NONE;
        total++; if (nb != 5) begin bad++; $display("FAIL busy_ignore_cycles got=%0d exp=5", nb); end
        total++; if (lo !== 32'd6 || hi !== 32'd0) begin bad++; $display("FAIL busy_ignore_res got=%h:%h exp=0:6", hi, lo); end
    endtask

    task automatic test_reset_mid;
        int nb;
        start = 1'b1; op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7; md_use = 1'b1;
        @(negedge clk);
        start = 1'b0; md_use = 1'b0; op = OP_NONE;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%0b exp=1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
            begin bad++; $display("FAIL mid_reset got busy=%0b %h:%h exp busy=0 0:0", busy, hi, lo); end
        repeat (12) @(negedge clk);
        total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL mid_discard got=%h:%h exp=0:0", hi, lo); end
        run_op(OP_MULT, 32'd4, 32'd5, nb);
        total++; if (nb != 5 || lo !== 32'd20) begin bad++; $display("FAIL post_reset_mult got nb=%0d lo=%h exp nb=5 lo=14", nb, lo); end
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd;
        int nb;
        start = 1'b1; op = OP_MTHI; rs_val = 32'd0;
        @(negedge clk);
        op = OP_MTLO; rs_val = 32'd10;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        run_op(OP_MADD, 32'd3, 32'd4, nb);
        total++; if (nb != 5 || hi !== 32'd0 || lo !== 32'd22) begin bad++; $display("FAIL madd got nb=%0d %h:%h exp nb=5 0:16", nb, hi, lo); end
        run_op(OP_MSUBU, 32'd1, 32'd23, nb);
        total++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL msubu got=%h:%h exp=ffffffff:ffffffff", hi, lo); end
    endtask
`else
    task automatic test_madd_off;
        start = 1'b1; op = OP_MADD; rs_val = 32'd3; rt_val = 32'd4;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL madd_off_busy got=%0b exp=0", busy); end
        repeat (6) @(negedge clk);
        total++; if (lo !== 32'd20 || hi !== 32'd0) begin bad++; $display("FAIL madd_off_keep got=%h:%h exp=0:14", hi, lo); end
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_mt_cancel();
        test_busy_ignore();
        test_reset_mid();
`ifdef MDU_MADD_EN
        test_madd();
`else
        test_madd_off();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
